// File: rtl/dsc_mul_sched.sv
// Round-robin scheduler sharing one serial stochastic-computing multiplier among NUM_REQ requesters.
// Each op runs clear -> run-until-ov (or timeout) -> hold result until the consumer accepts it.
module dsc_mul_sched #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_BITS = 10,
  parameter int CYC_W    = 21,
  parameter int TIMEOUT  = 1050000,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*NUM_BITS-1:0]  req_a,
  input  logic [NUM_REQ*NUM_BITS-1:0]  req_b,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [ID_W-1:0]              resp_id,
  output logic [2*NUM_BITS-1:0]        resp_z,
  output logic [CYC_W-1:0]             resp_cycles,
  output logic                         resp_timeout,
  output logic                         busy,
  output logic                         mul_rst,
  output logic                         mul_en,
  output logic [NUM_BITS-1:0]          mul_a,
  output logic [NUM_BITS-1:0]          mul_b,
  input  logic [2*NUM_BITS-1:0]        mul_z,
  input  logic                         mul_ov
);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT - 1);
  localparam logic [CYC_W-1:0] CYC_MAX  = CYC_W'(TIMEOUT);
  localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   grant_id;
  logic              grant_vld;
  logic [CYC_W-1:0]  cyc_cnt;
  logic              run_end;

  // Returns {found, index} of the first valid requester strictly after 'last', wrapping around.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                            input logic [ID_W-1:0]    last);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last) + i) % NUM_REQ;
      if (vld[idx]) res = {1'b1, ID_W'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    {grant_vld, grant_id} = rr_pick(req_valid, ptr);
  end

  assign run_end = mul_ov || (cyc_cnt == CYC_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = CLEAR;
      CLEAR:   state_nxt = RUN;
      RUN:     if (run_end) state_nxt = DONE;
      DONE:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_vld && !rst) req_ready[grant_id] = 1'b1;
    mul_rst    = rst || (state == CLEAR);
    mul_en     = (state == RUN) && !rst;
    resp_valid = (state == DONE);
    busy       = (state != IDLE);
  end

  // Operand latch at grant, cycle counting in RUN, result capture on ov or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= PTR_INIT;
      mul_a        <= '0;
      mul_b        <= '0;
      resp_id      <= '0;
      cyc_cnt      <= '0;
      resp_z       <= '0;
      resp_cycles  <= '0;
      resp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            mul_a   <= req_a[int'(grant_id)*NUM_BITS +: NUM_BITS];
            mul_b   <= req_b[int'(grant_id)*NUM_BITS +: NUM_BITS];
            resp_id <= grant_id;
            ptr     <= grant_id;
          end
        end
        CLEAR: cyc_cnt <= '0;
        RUN: begin
          cyc_cnt <= cyc_cnt + 1'b1;
          if (mul_ov) begin
            resp_z       <= mul_z;
            resp_cycles  <= cyc_cnt + 1'b1;
            resp_timeout <= 1'b0;
          end else if (cyc_cnt == CYC_LAST) begin
            resp_z       <= '0;
            resp_cycles  <= CYC_MAX;
            resp_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsc_mul_sched.sv
// Self-checking bench for dsc_mul_sched with a behavioural multiplier whose ov latency is programmable.
module tb_dsc_mul_sched;
  localparam int NR = 4;
  localparam int NB = 10;
  localparam int CW = 21;
  localparam int TO = 16;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*NB-1:0]  req_a, req_b;
  logic              resp_valid, resp_ready;
  logic [IW-1:0]     resp_id;
  logic [2*NB-1:0]   resp_z;
  logic [CW-1:0]     resp_cycles;
  logic              resp_timeout, busy, mul_rst, mul_en;
  logic [NB-1:0]     mul_a, mul_b;
  logic [2*NB-1:0]   mul_z;
  logic              mul_ov;

  logic [NB-1:0]     opa [NR];
  logic [NB-1:0]     opb [NR];
  int                checks = 0;
  int                errors = 0;
  int                mptr;
  int                mk = 0;
  int                mcnt = 0;

  dsc_mul_sched #(.NUM_REQ(NR), .NUM_BITS(NB), .CYC_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_z(resp_z), .resp_cycles(resp_cycles),
    .resp_timeout(resp_timeout), .busy(busy), .mul_rst(mul_rst), .mul_en(mul_en),
    .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z), .mul_ov(mul_ov)
  );

  always #5 clk = ~clk;

  for (genvar i = 0; i < NR; i++) begin : g_pack
    assign req_a[i*NB +: NB] = opa[i];
    assign req_b[i*NB +: NB] = opb[i];
  end

  // Multiplier model: ov during the mk-th enabled cycle after a clear (mk = 0 never finishes).
  always @(posedge clk) begin
    if (mul_rst)     mcnt <= 0;
    else if (mul_en) mcnt <= mcnt + 1;
  end
  assign mul_ov = mul_en && (mk != 0) && (mcnt == mk - 1);
  assign mul_z  = mul_ov ? ({10'b0, mul_a} * {10'b0, mul_b}) : 20'hABCDE;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int pred(input logic [NR-1:0] m);
    for (int i = 1; i <= NR; i++)
      if (m[(mptr + i) % NR]) return (mptr + i) % NR;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mptr = NR - 1;
  endtask

  // One complete op: wait for a grant, follow CLEAR/RUN, check the response, hold, handshake.
  task automatic do_op(input int k, input int hold, input bit drop,
                       input int e_id, input longint e_z, input int e_cyc, input bit e_to);
    int n, g, en_cnt;
    bit ok;
    logic [IW-1:0]   sid;
    logic [2*NB-1:0] sz;
    mk = k;
    n = 0;
    #1;
    while (req_ready == '0 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    if (req_ready == '0) begin
      chk("grant_wait", 0, 1);
      return;
    end
    chk("ready_onehot", $countones(req_ready), 1);
    g = 0;
    for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
    chk("grant_id", g, e_id);
    mptr = g;
    @(negedge clk);
    if (drop) req_valid[g] = 1'b0;
    #1;
    chk("clear_mul_rst", mul_rst, 1);
    chk("clear_mul_en", mul_en, 0);
    en_cnt = 0; ok = 1'b1; n = 0;
    @(negedge clk); #1;
    while (!resp_valid && n < TO + 8) begin
      if (mul_en) en_cnt++;
      if (mul_rst || mul_a !== opa[g] || mul_b !== opb[g] || req_ready != '0) ok = 1'b0;
      @(negedge clk); #1; n++;
    end
    chk("run_stable", ok, 1);
    chk("resp_valid", resp_valid, 1);
    chk("en_cycles", en_cnt, e_cyc);
    chk("resp_id", resp_id, e_id);
    chk("resp_z", resp_z, e_z);
    chk("resp_cycles", resp_cycles, e_cyc);
    chk("resp_timeout", resp_timeout, e_to);
    sid = resp_id; sz = resp_z; ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      if (!resp_valid || resp_id !== sid || resp_z !== sz || mul_en || req_ready != '0) ok = 1'b0;
    end
    if (hold > 0) chk("done_hold", ok, 1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    chk("busy_after", busy, 0);
    chk("resp_valid_after", resp_valid, 0);
  endtask

  typedef struct {
    int     id;
    int     a;
    int     b;
    int     k;
    int     hold;
    longint z;
    int     cyc;
    bit     to;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int     e, k, hold;
    bit     eto;
    longint ez;
    logic [NR-1:0] m;
    int     fair_ids [9];

    tbl[0] = '{0, 3,    5,    7,  0, 15,      7,  0};
    tbl[1] = '{2, 1023, 1023, 9,  1, 1046529, 9,  0};
    tbl[2] = '{1, 0,    517,  5,  0, 0,       5,  0};
    tbl[3] = '{3, 6,    7,    0,  2, 0,       16, 1};
    tbl[4] = '{0, 1023, 1,    16, 0, 1023,    16, 0};
    tbl[5] = '{0, 2,    2,    17, 0, 0,       16, 1};
    tbl[6] = '{1, 1,    1,    1,  0, 1,       1,  0};
    tbl[7] = '{3, 512,  1000, 12, 3, 512000,  12, 0};
    fair_ids = '{0, 1, 2, 3, 0, 1, 3, 1, 3};

    for (int i = 0; i < NR; i++) begin opa[i] = '0; opb[i] = '0; end
    req_valid = 4'hF;
    resp_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_mul_rst", mul_rst, 1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mul_en", mul_en, 0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    mptr = NR - 1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_z", resp_z, 0);
    chk("rst_resp_cycles", resp_cycles, 0);
    chk("rst_resp_timeout", resp_timeout, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("idle_mul_rst", mul_rst, 0);

    // Withdrawal before the grant edge leaves the scheduler untouched.
    req_valid = 4'b0010; #1;
    chk("withdraw_ready", req_ready, 4'b0010);
    req_valid = '0;
    @(negedge clk); #1;
    chk("withdraw_busy", busy, 0);

    for (int t = 0; t < 8; t++) begin
      opa[tbl[t].id] = NB'(tbl[t].a);
      opb[tbl[t].id] = NB'(tbl[t].b);
      req_valid = NR'(1) << tbl[t].id;
      do_op(tbl[t].k, tbl[t].hold, 1'b1, tbl[t].id, tbl[t].z, tbl[t].cyc, tbl[t].to);
      req_valid = '0;
    end

    // Fairness: all requesters, then only 1 and 3, kept asserted throughout.
    do_reset();
    for (int i = 0; i < NR; i++) begin opa[i] = NB'(10 + i); opb[i] = NB'(20 + i); end
    req_valid = 4'hF;
    for (int t = 0; t < 9; t++) begin
      if (t == 5) req_valid = 4'b1010;
      e = fair_ids[t];
      do_op(3, 0, 1'b0, e, longint'(opa[e]) * longint'(opb[e]), 3, 1'b0);
    end
    req_valid = '0;

    // Long DONE hold with requester 2 waiting, then immediate grant after the handshake.
    do_reset();
    opa[0] = 11; opb[0] = 13; opa[2] = 17; opb[2] = 19;
    req_valid = 4'b0101;
    do_op(4, 10, 1'b1, 0, 143, 4, 1'b0);
    chk("grant_after_hs", req_ready, 4'b0100);
    do_op(6, 0, 1'b1, 2, 323, 6, 1'b0);
    req_valid = '0;

    // Reset mid-RUN drops the op and restores the pointer.
    opa[0] = 9; opb[0] = 9; mk = 0;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    chk("midrun_busy", busy, 1);
    chk("midrun_mul_en", mul_en, 1);
    rst = 1'b1; #1;
    chk("midrun_rst_mul_rst", mul_rst, 1);
    @(negedge clk);
    rst = 1'b0;
    mptr = NR - 1;
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_resp_valid", resp_valid, 0);
    chk("post_rst_mul_en", mul_en, 0);
    opa[3] = 2; opb[3] = 3;
    req_valid = 4'b1001;
    do_op(2, 0, 1'b1, 0, 81, 2, 1'b0);
    req_valid = '0;
    opa[2] = 6; opb[2] = 7;
    req_valid = 4'b0100;
    do_op(7, 0, 1'b1, 2, 42, 7, 1'b0);
    req_valid = '0;

    // Randomized ops against the round-robin and timeout reference.
    for (int t = 0; t < 20; t++) begin
      m = NR'($urandom_range(1, 15));
      for (int i = 0; i < NR; i++) begin opa[i] = NB'($urandom); opb[i] = NB'($urandom); end
      k = $urandom_range(0, 19);
      hold = $urandom_range(0, 2);
      e = pred(m);
      eto = !(k != 0 && k <= TO);
      ez = eto ? 0 : longint'(opa[e]) * longint'(opb[e]);
      req_valid = m;
      do_op(k, hold, 1'b1, e, ez, eto ? TO : k, eto);
      req_valid = '0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsc_mul_sched.md
Name: dsc_mul_sched

Overview:
- Round-robin scheduler that shares one dsc_mul instance (serial deterministic stochastic-computing multiplier) among NUM_REQ requesters.
- Accepts operand pairs over valid/ready.
- Sequences the multiplier: clear pulse, enable until ov, capture z.
- Returns the product with requester id, the run cycle count and a timeout flag.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
NUM_BITS, 10, operand width; product width is 2*NUM_BITS
CYC_W, 21, width of the run-cycle counter; must satisfy 2^CYC_W > TIMEOUT
TIMEOUT, 1050000, maximum RUN cycles before the op is aborted
ID_W, derived localparam = clog2(NUM_REQ)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit high
req_a  in  NUM_REQ*NUM_BITS  operand a, requester i at [i*NUM_BITS +: NUM_BITS]
req_b  in  NUM_REQ*NUM_BITS  operand b, same packing
resp_valid  out  1  result available
resp_ready  in  1  result consumer accept
resp_id  out  ID_W  requester index of the result
resp_z  out  2*NUM_BITS  product
resp_cycles  out  CYC_W  RUN-state cycles spent on the op
resp_timeout  out  1  op aborted by timeout; resp_z is 0
busy  out  1  state != IDLE
mul_rst  out  1  to dsc_mul rst
mul_en  out  1  to dsc_mul en
mul_a  out  NUM_BITS  to dsc_mul a
mul_b  out  NUM_BITS  to dsc_mul b
mul_z  in  2*NUM_BITS  from dsc_mul z
mul_ov  in  1  from dsc_mul ov (op finished)

Behaviour:
- FSM states: IDLE, CLEAR, RUN, DONE.
- Reset values:
  - state = IDLE.
  - Every output register = 0: resp_*, mul_en, mul_a, mul_b, cycle counter.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
  - req_ready = 0.
  - mul_rst = 1 while rst is high (mul_rst = rst | state==CLEAR).
- IDLE:
  - If any req_valid is high, grant g = first valid index strictly after the pointer, circularly.
  - req_ready[g] = 1 combinationally in that same cycle, and only in IDLE.
  - On that edge: latch req_a[g] -> mul_a, req_b[g] -> mul_b, g -> id, pointer <= g; go to CLEAR.
  - Otherwise stay in IDLE.
- CLEAR (1 cycle): mul_rst = 1, mul_en = 0, cycle counter <= 0; go to RUN.
- RUN:
  - mul_en = 1, mul_rst = 0; counter increments every RUN cycle.
  - If mul_ov = 1 is sampled: resp_z <= mul_z, resp_cycles <= counter+1, resp_timeout <= 0; go to DONE.
  - Else if counter == TIMEOUT-1: resp_z <= 0, resp_cycles <= TIMEOUT, resp_timeout <= 1; go to DONE.
  - If mul_ov and the timeout occur in the same cycle, mul_ov wins.
- DONE:
  - mul_en = 0, resp_valid = 1.
  - resp_id, resp_z, resp_cycles, resp_timeout are held stable until resp_valid & resp_ready, then go to IDLE.
  - Next grant is at earliest the cycle after the handshake.
- mul_a/mul_b are stable from the latch until the next grant and never change during CLEAR or RUN.
- mul_ov is ignored outside RUN.
- Timing:
  - Handshake-to-result latency = 1 (CLEAR) + RUN cycles + 1.
  - Minimum grant-to-grant spacing = RUN cycles + 3, with resp_ready tied high.
- Fairness: a continuously asserted requester waits at most NUM_REQ-1 ops.
- Withdrawal: a requester may drop req_valid before it is granted, with no side effects.
- Reset in any state:
  - Next state is IDLE; the in-flight op is dropped with no response.
  - Pointer returns to NUM_REQ-1.
- Counter: never wraps, because the TIMEOUT bound applies.

Test Plan:
- Behavioural mul model returns ov on the 7th enabled cycle with z=a*b. Requester 0: a=3, b=5 -> req_ready[0] pulses one cycle; mul_rst high 1 cycle; mul_en high 7 cycles; resp_valid with resp_id=0, resp_z=15, resp_cycles=7, resp_timeout=0.
- All 4 req_valid held high from reset -> grant order 0,1,2,3,0. Then only requesters 1 and 3 held valid -> order 1,3,1,3. Never two req_ready bits high at once.
- resp_ready low for 10 cycles in DONE -> resp_valid, resp_id, resp_z stay constant; mul_en=0; no req_ready while req_valid[2]=1. Grant to requester 2 one cycle after the handshake.
- TIMEOUT=16 and model never asserts ov -> resp_timeout=1, resp_z=0, resp_cycles=16, busy clears after the handshake.
- rst pulsed for 1 cycle mid-RUN -> next cycle state=IDLE, resp_valid=0, mul_en=0, mul_rst=1 during rst. A subsequent request from requester 2 (a=6, b=7) completes with resp_z=42.
- Real dsc_mul (NUM_BITS=10) with a=1023, b=1023 and with a=0, b=517 -> resp_z=1046529 and resp_z=0, both with resp_timeout=0.
